// File: rtl/trace_history_ctrl_if.sv
// Bundles the raster position, sample handshake and plot outputs of the
// trace history controller. The master drives the position and samples.
interface trace_history_ctrl_if;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [4:0]  matrix_x;
    logic [8:0]  matrix_y;
    logic        sample_valid;
    logic [8:0]  sample_level;
    logic        clear;
    logic        sample_ready;
    logic [4:0]  count;
    logic        clamp_event;
    logic        commit_done;
    logic        trace_pixel;

    modport master (
        output hc, vc, matrix_x, matrix_y, sample_valid, sample_level, clear,
        input  sample_ready, count, clamp_event, commit_done, trace_pixel
    );

    modport slave (
        input  hc, vc, matrix_x, matrix_y, sample_valid, sample_level, clear,
        output sample_ready, count, clamp_event, commit_done, trace_pixel
    );
endinterface

// File: rtl/trace_history_ctrl.sv
// Sample-history controller for the column temperature plot. Samples land in
// a ring; once per frame, on the commit line, the ring is copied oldest-first
// into a display bank that the pixel path reads, so the trace never tears.
module trace_history_ctrl #(
    parameter int NUM_COLS     = 20,
    parameter int NUM_ROWS     = 300,
    parameter int CUADRILLA_XI = 212,
    parameter int CUADRILLA_XF = 712,
    parameter int CUADRILLA_YI = 184,
    parameter int CUADRILLA_YF = 484,
    parameter int COMMIT_LINE  = 490
) (
    input  logic                clk,
    input  logic                rst,
    trace_history_ctrl_if.slave bus
);

    localparam logic [4:0]  LAST_COL  = 5'(NUM_COLS - 1);
    localparam logic [4:0]  NCOLS5    = 5'(NUM_COLS);
    localparam logic [5:0]  NCOLS6    = 6'(NUM_COLS);
    localparam logic [8:0]  MAX_LVL   = 9'(NUM_ROWS - 1);
    localparam logic [9:0]  MAX_LVL10 = 10'(NUM_ROWS - 1);
    localparam logic [10:0] XI        = 11'(CUADRILLA_XI);
    localparam logic [10:0] XF        = 11'(CUADRILLA_XF);
    localparam logic [10:0] YI        = 11'(CUADRILLA_YI);
    localparam logic [10:0] YF        = 11'(CUADRILLA_YF);
    localparam logic [10:0] CLINE     = 11'(COMMIT_LINE);

    typedef enum logic {IDLE, COPY} state_t;

    state_t              state_q, state_d;
    logic [8:0]          ring_q [NUM_COLS];
    logic [8:0]          ring_d [NUM_COLS];
    logic [8:0]          disp_level_q [NUM_COLS];
    logic [8:0]          disp_level_d [NUM_COLS];
    logic [NUM_COLS-1:0] disp_valid_q, disp_valid_d;
    logic [4:0]          wr_ptr_q, wr_ptr_d;
    logic [4:0]          count_q, count_d;
    logic [4:0]          idx_q, idx_d;
    logic [4:0]          oldest_s_q, oldest_s_d;
    logic [4:0]          count_s_q, count_s_d;
    logic                dirty_q, dirty_d;
    logic                clear_pend_q, clear_pend_d;
    logic                clamp_q, clamp_d;
    logic                in_grid, in_grid_q;
    logic                trace_q, trace_d;
    logic                sample_ready;
    logic                over;
    logic [5:0]          rd_sum;
    logic [4:0]          rd_idx;

    // Oldest ring slot: wr_ptr - count, borrowing back into range on underflow.
    function automatic logic [4:0] oldest_of(logic [4:0] ptr, logic [4:0] cnt);
        logic [5:0] diff;
        diff = {1'b0, ptr} - {1'b0, cnt};
        if (diff[5]) diff = diff + NCOLS6;
        return diff[4:0];
    endfunction

    assign sample_ready = (state_q == IDLE) && !bus.clear && !clear_pend_q;
    assign over         = bus.sample_level > MAX_LVL;
    assign in_grid      = (bus.hc > XI) && (bus.hc <= XF) && (bus.vc > YI) && (bus.vc <= YF);

    // Ring slot read on the current copy step.
    always_comb begin
        rd_sum = {1'b0, oldest_s_q} + {1'b0, idx_q};
        if (rd_sum >= NCOLS6) rd_sum = rd_sum - NCOLS6;
        rd_idx = rd_sum[4:0];
    end

    // Ring writes, clear handling and the IDLE/COPY commit sequencer.
    always_comb begin
        state_d      = state_q;
        ring_d       = ring_q;
        disp_level_d = disp_level_q;
        disp_valid_d = disp_valid_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        idx_d        = idx_q;
        oldest_s_d   = oldest_s_q;
        count_s_d    = count_s_q;
        dirty_d      = dirty_q;
        clear_pend_d = clear_pend_q;
        clamp_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear || clear_pend_q) begin
                    wr_ptr_d     = '0;
                    count_d      = '0;
                    dirty_d      = 1'b1;
                    clear_pend_d = 1'b0;
                end else if (bus.sample_valid) begin
                    ring_d[wr_ptr_q] = over ? MAX_LVL : bus.sample_level;
                    wr_ptr_d         = (wr_ptr_q == LAST_COL) ? 5'd0 : wr_ptr_q + 5'd1;
                    if (count_q < NCOLS5) count_d = count_q + 5'd1;
                    dirty_d = 1'b1;
                    clamp_d = over;
                end
                // Snapshot the post-update ring so a same-cycle write or clear
                // is part of this commit rather than lost when dirty drops.
                if ((bus.vc == CLINE) && (bus.hc == 11'd0) && dirty_q) begin
                    state_d    = COPY;
                    idx_d      = '0;
                    oldest_s_d = oldest_of(wr_ptr_d, count_d);
                    count_s_d  = count_d;
                end
            end
            COPY: begin
                disp_level_d[idx_q] = ring_q[rd_idx];
                disp_valid_d[idx_q] = idx_q < count_s_q;
                if (bus.clear) clear_pend_d = 1'b1;
                if (idx_q == LAST_COL) begin
                    state_d = IDLE;
                    dirty_d = 1'b0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel lookup: grid gate aligned with matrix_x/matrix_y, level match per column.
    always_comb begin
        trace_d = 1'b0;
        if (bus.matrix_x < NCOLS5) begin
            trace_d = in_grid_q && disp_valid_q[bus.matrix_x] &&
                      (({1'b0, disp_level_q[bus.matrix_x]} + {1'b0, bus.matrix_y}) == MAX_LVL10);
        end
    end

    // Control state and pixel pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            disp_valid_q <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            oldest_s_q   <= '0;
            count_s_q    <= '0;
            dirty_q      <= 1'b0;
            clear_pend_q <= 1'b0;
            clamp_q      <= 1'b0;
            in_grid_q    <= 1'b0;
            trace_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_valid_q <= disp_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            oldest_s_q   <= oldest_s_d;
            count_s_q    <= count_s_d;
            dirty_q      <= dirty_d;
            clear_pend_q <= clear_pend_d;
            clamp_q      <= clamp_d;
            in_grid_q    <= in_grid;
            trace_q      <= trace_d;
        end
    end

    // Level storage; contents are qualified by count / disp_valid, so no reset.
    always_ff @(posedge clk) begin
        ring_q       <= ring_d;
        disp_level_q <= disp_level_d;
    end

    assign bus.sample_ready = sample_ready;
    assign bus.count        = count_q;
    assign bus.clamp_event  = clamp_q;
    assign bus.commit_done  = (state_q == COPY) && (idx_q == LAST_COL);
    assign bus.trace_pixel  = trace_q;

endmodule

// File: tb/tb_trace_history_ctrl.sv
// Bench for trace_history_ctrl: a queue-based history model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_trace_history_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trace_history_ctrl_if bus();
    trace_history_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    endtask

    // ---------------- behavioural model ----------------
    int q[$];
    int snap[$];
    bit m_dirty, m_pend, m_copy, m_clamp, m_ingrid, m_pix;
    int m_i;
    int d_lvl[20];
    bit d_vld[20];
    bit armed = 0;
    int clamp_seen = 0;

    task automatic model_step();
        int mx, my, lv;
        bit start;
        if (rst) begin
            q.delete(); snap.delete();
            m_dirty = 0; m_pend = 0; m_copy = 0; m_i = 0;
            m_clamp = 0; m_ingrid = 0; m_pix = 0;
            for (int k = 0; k < 20; k++) d_vld[k] = 0;
            armed = 1;
        end else begin
            mx = int'(bus.matrix_x);
            my = int'(bus.matrix_y);
            m_pix = m_ingrid && (mx < 20) && d_vld[mx] && (299 - my == d_lvl[mx]);
            m_ingrid = (bus.hc > 212) && (bus.hc <= 712) && (bus.vc > 184) && (bus.vc <= 484);
            m_clamp = 0;
            if (m_copy) begin
                d_vld[m_i] = (m_i < snap.size());
                if (m_i < snap.size()) d_lvl[m_i] = snap[m_i];
                if (bus.clear) m_pend = 1;
                if (m_i == 19) begin m_copy = 0; m_dirty = 0; end
                else m_i++;
            end else begin
                start = (bus.vc == 490) && (bus.hc == 0) && m_dirty;
                if (bus.clear || m_pend) begin
                    q.delete(); m_dirty = 1; m_pend = 0;
                end else if (bus.sample_valid) begin
                    lv = int'(bus.sample_level);
                    m_clamp = lv > 299;
                    q.push_back(lv > 299 ? 299 : lv);
                    if (q.size() > 20) void'(q.pop_front());
                    m_dirty = 1;
                end
                if (start) begin snap = q; m_copy = 1; m_i = 0; end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("sample_ready", bus.sample_ready, !m_copy && !bus.clear && !m_pend);
            chk("count", bus.count, q.size());
            chk("clamp_event", bus.clamp_event, m_clamp);
            chk("commit_done", bus.commit_done, m_copy && (m_i == 19));
            chk("trace_pixel", bus.trace_pixel, m_pix);
            if (bus.clamp_event === 1'b1) clamp_seen <= clamp_seen + 1;
        end
    end

    // ---------------- stimulus ----------------
    int prev_h = 0, prev_v = 0;
    int lit[20];
    int done_at, ready_lo;

    function automatic int col_of(int h);
        return (h > 212 && h <= 712) ? (h - 213) / 25 : 0;
    endfunction
    function automatic int row_of(int v);
        return (v > 184 && v <= 484) ? v - 185 : 0;
    endfunction

    // Advance one cycle; matrix_x/y follow hc/vc by one cycle like the grid generator.
    task automatic step(int h, int v);
        @(posedge clk); #1;
        bus.matrix_x = 5'(col_of(prev_h));
        bus.matrix_y = 9'(row_of(prev_v));
        bus.hc = 11'(h);
        bus.vc = 11'(v);
        prev_h = h; prev_v = v;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            step(0, 0);
            bus.sample_valid = 0; bus.clear = 0;
        end
    endtask

    task automatic push(int lv);
        step(0, 0);
        bus.sample_valid = 1; bus.sample_level = 9'(lv); bus.clear = 0;
    endtask

    // Hit the commit point and run 25 cycles past it.
    task automatic commit(bit hold, int clear_at, int rst_at, int exp_cnt);
        step(0, 490);
        bus.sample_valid = 0; bus.clear = 0;
        done_at = -1; ready_lo = 0;
        for (int n = 1; n <= 25; n++) begin
            step(n, 490);
            bus.clear = (n == clear_at);
            bus.sample_valid = hold && (n <= 20);
            bus.sample_level = 9'd77;
            rst = (n == rst_at);
            @(negedge clk);
            if (bus.commit_done === 1'b1 && done_at < 0) done_at = n;
            if (n <= 20 && bus.sample_ready === 1'b0) ready_lo++;
            if (hold && n == 20) chk("hold_count", bus.count, exp_cnt);
            if (clear_at > 0 && n == 21) chk("clear_pend_count", bus.count, exp_cnt);
            if (clear_at > 0 && n == 22) chk("clear_applied_count", bus.count, 0);
        end
        bus.sample_valid = 0; bus.clear = 0; rst = 0;
    endtask

    // Raster every grid row of every column centre, recording the lit row per column.
    task automatic scan();
        int t1c, t1r, t2c, t2r;
        t1c = -1; t1r = 0; t2c = -1; t2r = 0;
        for (int k = 0; k < 20; k++) lit[k] = -1;
        for (int c = 0; c <= 20; c++) begin
            for (int r = 0; r < ((c == 20) ? 2 : 300); r++) begin
                if (c == 20) step(0, 0); else step(225 + 25 * c, 185 + r);
                @(negedge clk);
                if (bus.trace_pixel === 1'b1 && t2c >= 0) lit[t2c] = t2r;
                t2c = t1c; t2r = t1r;
                t1c = (c == 20) ? -1 : c; t1r = r;
            end
        end
    endtask

    function automatic int dark();
        int d = 0;
        for (int k = 0; k < 20; k++) if (lit[k] < 0) d++;
        return d;
    endfunction

    initial begin
        bus.hc = 0; bus.vc = 0; bus.matrix_x = 0; bus.matrix_y = 0;
        bus.sample_valid = 0; bus.sample_level = 0; bus.clear = 0;
        rst = 1;
        idle(3);
        rst = 0;
        @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.sample_ready, 1);
        chk("rst_clamp", bus.clamp_event, 0);
        chk("rst_done", bus.commit_done, 0);
        chk("rst_pixel", bus.trace_pixel, 0);

        // basic plot
        push(10); push(20); push(30); idle(1);
        @(negedge clk); chk("basic_count", bus.count, 3);
        commit(0, 0, 0, 3);
        chk("basic_done_at", done_at, 20);
        chk("basic_ready_lo", ready_lo, 20);
        scan();
        chk("basic_col0", lit[0], 289);
        chk("basic_col1", lit[1], 279);
        chk("basic_col2", lit[2], 269);
        chk("basic_dark", dark(), 17);

        // idle frame: nothing new, no commit, display kept
        commit(0, 0, 0, 3);
        chk("idle_done_at", done_at, -1);
        scan();
        chk("idle_col0", lit[0], 289);
        chk("idle_dark", dark(), 17);

        // wrap
        step(0, 0); bus.clear = 1;
        for (int v = 0; v < 25; v++) push(v);
        idle(1);
        @(negedge clk); chk("wrap_count", bus.count, 20);
        commit(0, 0, 0, 20);
        scan();
        chk("wrap_col0", lit[0], 294);
        chk("wrap_col19", lit[19], 275);

        // clamp
        push(400); idle(2);
        @(negedge clk); chk("clamp_pulses", clamp_seen, 1);
        commit(0, 0, 0, 20);
        scan();
        chk("clamp_col19", lit[19], 0);
        chk("clamp_col0", lit[0], 293);

        // clear collides with a sample
        step(0, 0); bus.clear = 1; bus.sample_valid = 1; bus.sample_level = 9'd55;
        idle(1);
        @(negedge clk); chk("collide_count", bus.count, 0);
        commit(0, 0, 0, 0);
        chk("collide_done_at", done_at, 20);
        scan();
        chk("collide_dark", dark(), 20);

        // backpressure through COPY
        push(100); idle(1);
        commit(1, 0, 0, 1);
        chk("bp_done_at", done_at, 20);
        chk("bp_ready_lo", ready_lo, 20);
        idle(1);
        @(negedge clk); chk("bp_count", bus.count, 1);

        // clear during COPY
        push(9); idle(1);
        commit(0, 5, 0, 2);
        chk("clrcopy_done_at", done_at, 20);

        // reset at copy step 7
        push(33); idle(1);
        commit(0, 0, 8, 0);
        chk("rst_copy_done_at", done_at, -1);
        @(negedge clk);
        chk("rst_copy_count", bus.count, 0);
        chk("rst_copy_ready", bus.sample_ready, 1);
        scan();
        chk("rst_copy_dark", dark(), 20);
        commit(0, 0, 0, 0);
        chk("rst_idle_done_at", done_at, -1);

        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
